// File: rtl/speaker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : speaker_pkg
// Description : Shared constants for the speaker path: note codes, the
//               pitch-code to tone-divider lookup and sequencer state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package speaker_pkg;

    // Width of the raw divider values held in the lookup
    localparam int LUT_W = 22;

    // Note codes stored in the melody tables
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;
    localparam logic [3:0] NOTE_D5   = 4'd9;
    localparam logic [3:0] NOTE_E5   = 4'd10;
    localparam logic [3:0] NOTE_F5   = 4'd11;
    localparam logic [3:0] NOTE_G5   = 4'd12;
    localparam logic [3:0] NOTE_A5   = 4'd13;
    localparam logic [3:0] NOTE_B5   = 4'd14;
    localparam logic [3:0] NOTE_END  = 4'd15;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NOTE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Pitch code to PWM divider; rest and END both map to silence (0)
    function automatic logic [LUT_W-1:0] note_divider(input logic [3:0] code);
        logic [LUT_W-1:0] div;
        case (code)
            NOTE_C4: div = 22'd95420;
            NOTE_D4: div = 22'd85034;
            NOTE_E4: div = 22'd75758;
            NOTE_F4: div = 22'd71633;
            NOTE_G4: div = 22'd63775;
            NOTE_A4: div = 22'd56818;
            NOTE_B4: div = 22'd50607;
            NOTE_C5: div = 22'd47710;
            NOTE_D5: div = 22'd42517;
            NOTE_E5: div = 22'd37879;
            NOTE_F5: div = 22'd35816;
            NOTE_G5: div = 22'd31888;
            NOTE_A5: div = 22'd28409;
            NOTE_B5: div = 22'd25303;
            default: div = '0;
        endcase
        return div;
    endfunction

endpackage : speaker_pkg
`default_nettype wire

// File: rtl/melody_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer_if
// Description : Control and tone-output bundle of the melody sequencer.
//               master = controller side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface melody_sequencer_if #(
    parameter int NUM_MELODIES = 2,
    parameter int MAX_STEPS    = 16,
    parameter int DIV_W        = 22
) ();
    localparam int MSW = (NUM_MELODIES > 1) ? $clog2(NUM_MELODIES) : 1;
    localparam int SW  = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    logic             start;
    logic             stop;
    logic [MSW-1:0]   melody_sel;
    logic             loop_en;
    logic [DIV_W-1:0] note_div_left;
    logic [DIV_W-1:0] note_div_right;
    logic [SW-1:0]    step_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, melody_sel, loop_en,
        input  note_div_left, note_div_right, step_idx, busy, done
    );

    modport slave (
        input  start, stop, melody_sel, loop_en,
        output note_div_left, note_div_right, step_idx, busy, done
    );
endinterface : melody_sequencer_if
`default_nettype wire

// File: rtl/melody_rom.sv
`default_nettype none
// ============================================================================
// Module      : melody_rom
// Description : Combinational note table: (melody, step) -> 4-bit note code.
//               Entries beyond a melody's end, and unknown melodies, read END.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_rom
    import speaker_pkg::*;
#(
    parameter int NUM_MELODIES = 2,
    parameter int MAX_STEPS    = 16,
    parameter int MEL_W        = 1,
    parameter int STEP_W       = 4
) (
    input  logic [MEL_W-1:0]  melody,
    input  logic [STEP_W-1:0] step,
    output logic [3:0]        code
);

    // Melody 0: short rising "win" fanfare
    function automatic logic [3:0] win_code(input int idx);
        logic [3:0] c;
        case (idx)
            0:       c = NOTE_C4;
            1:       c = NOTE_E4;
            2:       c = NOTE_G4;
            3:       c = NOTE_C5;
            4:       c = NOTE_REST;
            5:       c = NOTE_G4;
            6:       c = NOTE_C5;
            default: c = NOTE_END;
        endcase
        return c;
    endfunction

    // Melody 1: falling "lose" phrase played twice
    function automatic logic [3:0] lose_code(input int idx);
        logic [3:0] c;
        case (idx)
            0, 5:    c = NOTE_G4;
            1, 6:    c = NOTE_F4;
            2, 7:    c = NOTE_E4;
            3, 8:    c = NOTE_C4;
            4, 9:    c = NOTE_REST;
            default: c = NOTE_END;
        endcase
        return c;
    endfunction

    // Table lookup; out-of-range selections read as END
    always_comb begin
        code = NOTE_END;
        if (int'(melody) < NUM_MELODIES && int'(step) < MAX_STEPS) begin
            case (int'(melody))
                0:       code = win_code(int'(step));
                1:       code = lose_code(int'(step));
                default: code = NOTE_END;
            endcase
        end
    end

endmodule : melody_rom
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Steps through a stored note table at a fixed tempo, inserting
//               a silent articulation gap at the end of each step, and drives
//               registered left/right tone dividers to the speaker PWM.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
    import speaker_pkg::*;
#(
    parameter int NUM_MELODIES   = 2,
    parameter int MAX_STEPS      = 16,
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000,
    parameter int DIV_W          = 22,
    parameter int STEREO_MODE    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    melody_sequencer_if.slave  bus
);

    localparam int SW  = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int MSW = (NUM_MELODIES > 1) ? $clog2(NUM_MELODIES) : 1;
    localparam int TW  = $clog2(TICKS_PER_STEP);

    // Last tick of the audible part of a step and last tick of the whole step
    localparam logic [TW-1:0] NOTE_LAST_TICK = TW'(TICKS_PER_STEP - GAP_TICKS - 1);
    localparam logic [TW-1:0] STEP_LAST_TICK = TW'(TICKS_PER_STEP - 1);
    localparam logic [SW-1:0] LAST_STEP      = SW'(MAX_STEPS - 1);

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tick_q,  tick_d;
    logic [SW-1:0]    step_q,  step_d;
    logic [MSW-1:0]   mel_q,   mel_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic [DIV_W-1:0] div_r_q, div_r_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             w_end_of_step;
    logic             w_last_step;
    logic [SW-1:0]    w_step_inc;
    logic [3:0]       w_code_start;
    logic [3:0]       w_code_next;
    logic [3:0]       w_code_first;

    assign w_step_inc = step_q + SW'(1);

    // Step 0 of the melody being requested by a start pulse
    melody_rom #(
        .NUM_MELODIES (NUM_MELODIES),
        .MAX_STEPS    (MAX_STEPS),
        .MEL_W        (MSW),
        .STEP_W       (SW)
    ) u_rom_start (
        .melody (bus.melody_sel),
        .step   ('0),
        .code   (w_code_start)
    );

    // Following step of the melody now playing
    melody_rom #(
        .NUM_MELODIES (NUM_MELODIES),
        .MAX_STEPS    (MAX_STEPS),
        .MEL_W        (MSW),
        .STEP_W       (SW)
    ) u_rom_next (
        .melody (mel_q),
        .step   (w_step_inc),
        .code   (w_code_next)
    );

    // Step 0 of the melody now playing, used when looping back
    melody_rom #(
        .NUM_MELODIES (NUM_MELODIES),
        .MAX_STEPS    (MAX_STEPS),
        .MEL_W        (MSW),
        .STEP_W       (SW)
    ) u_rom_first (
        .melody (mel_q),
        .step   ('0),
        .code   (w_code_first)
    );

    // The final table slot ends the melody even when it does not hold END
    assign w_last_step = (step_q == LAST_STEP) || (w_code_next == NOTE_END);

    function automatic logic [DIV_W-1:0] to_div(input logic [3:0] code);
        return DIV_W'(note_divider(code));
    endfunction

    // Next-state, tick/step counters and next output values
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        step_d        = step_q;
        mel_d         = mel_q;
        div_l_d       = div_l_q;
        done_d        = 1'b0;
        w_end_of_step = 1'b0;

        if (bus.stop) begin
            // Stop has priority over a coincident start
            state_d = ST_IDLE;
            tick_d  = '0;
            step_d  = '0;
            div_l_d = '0;
        end else if (bus.start) begin
            mel_d  = bus.melody_sel;
            step_d = '0;
            tick_d = '0;
            if (w_code_start == NOTE_END) begin
                // Empty melody finishes immediately
                state_d = ST_IDLE;
                div_l_d = '0;
                done_d  = 1'b1;
            end else begin
                state_d = ST_NOTE;
                div_l_d = to_div(w_code_start);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_NOTE: begin
                    if (tick_q == NOTE_LAST_TICK) begin
                        if (GAP_TICKS == 0) begin
                            w_end_of_step = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            tick_d  = tick_q + TW'(1);
                            div_l_d = '0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (tick_q == STEP_LAST_TICK) begin
                        w_end_of_step = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    step_d  = '0;
                    div_l_d = '0;
                end
            endcase

            if (w_end_of_step) begin
                tick_d = '0;
                if (w_last_step) begin
                    if (bus.loop_en) begin
                        state_d = ST_NOTE;
                        step_d  = '0;
                        div_l_d = to_div(w_code_first);
                    end else begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                        div_l_d = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_NOTE;
                    step_d  = w_step_inc;
                    div_l_d = to_div(w_code_next);
                end
            end
        end

        // Octave-down right channel; silence stays 0 after the shift
        if (STEREO_MODE != 0) begin
            div_r_d = div_l_d << 1;
        end else begin
            div_r_d = div_l_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            step_q  <= '0;
            mel_q   <= '0;
            div_l_q <= '0;
            div_r_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            mel_q   <= mel_d;
            div_l_q <= div_l_d;
            div_r_q <= div_r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.note_div_left  = div_l_q;
    assign bus.note_div_right = div_r_q;
    assign bus.step_idx       = step_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule : melody_sequencer
`default_nettype wire

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored note sequence on the stereo speaker path. It steps through a per-melody note table at a fixed tempo, inserts an articulation gap (silence) between notes, and drives registered left/right tone dividers into the existing speaker PWM generator. It is the parametrised successor to the fixed index-to-divider lookups: it owns the step timing, supports multiple melodies, one-shot or loop playback, and a stereo octave mode.

## Interface
- NUM_MELODIES, 2, number of stored melodies (0 = win, 1 = lose)
- MAX_STEPS, 16, table depth per melody; step index width SW = clog2(MAX_STEPS)
- TICKS_PER_STEP, 12_500_000, clk cycles per step (0.125 s at 100 MHz); must be ≥ 2
- GAP_TICKS, 1_250_000, silent cycles at the end of each step; must be < TICKS_PER_STEP; 0 means legato
- DIV_W, 22, divider output width
- STEREO_MODE, 0, 0 = both channels equal; 1 = right channel one octave down (divider << 1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that (re)starts playback of melody_sel from step 0
- stop  in  1  single-cycle pulse that aborts playback
- melody_sel  in  clog2(NUM_MELODIES)  melody to play; sampled only on start
- loop_en  in  1  when 1, playback restarts at step 0 instead of finishing; sampled every cycle
- note_div_left  out  DIV_W  left divider; 0 = silence
- note_div_right  out  DIV_W  right divider; 0 = silence
- step_idx  out  SW  current step
- busy  out  1  high in NOTE and GAP
- done  out  1  one-cycle pulse on natural completion (not on stop)

## Operation
- The note table holds 4-bit codes: 0 = rest, 1–14 = pitch, 15 = END. Pitch codes map to dividers through a constant LUT, e.g. G = 63775, F = 71633, E = 75758, C = 95420.
- Melody 1 (lose) is G, F, E, C, rest, G, F, E, C, rest, END.
- Unused entries are END. Step MAX_STEPS−1 is treated as last even without END.
- States:
  - IDLE: outputs 0.
  - NOTE: outputs the divider for the current code. A rest outputs 0.
  - GAP: outputs 0, but busy stays 1.
- Transitions:
  - IDLE→NOTE on start. This latches melody_sel, clears step_idx and the tick counter.
  - NOTE→GAP when the tick counter reaches TICKS_PER_STEP−GAP_TICKS−1. If GAP_TICKS = 0, go directly to end-of-step.
  - GAP→end-of-step when the tick counter reaches TICKS_PER_STEP−1.
- End-of-step:
  - If the next code is END or the step is last: with loop_en=1, go to NOTE at step 0; otherwise go to IDLE and pulse done.
  - Otherwise, go to NOTE at step_idx+1.
- If step 0 is END, start goes to IDLE on the next cycle with a done pulse.
- Any state →IDLE on stop, with no done pulse.
- start while busy restarts at step 0 with the newly sampled melody_sel.
- If start and stop arrive in the same cycle, stop wins.
- Right channel: if STEREO_MODE=1, it equals the left divider shifted left by 1, truncated to DIV_W (all LUT values fit). Silence stays 0.

## Timing
- All outputs are registered. Reset value is 0 for note_div_left, note_div_right, step_idx, busy and done. State resets to IDLE, tick counter to 0.
- Start in cycle t: at t+1, busy=1, step_idx=0 and the dividers show step 0.
- Each step lasts exactly TICKS_PER_STEP cycles. Dividers are non-zero for the first TICKS_PER_STEP−GAP_TICKS cycles of the step.
- Natural finish: in the cycle after the last step's final tick, busy=0, the dividers are 0 and done=1 for one cycle.
- Stop in cycle t: at t+1, outputs are 0 and busy=0.
- Reset asserted mid-play forces reset values immediately, without waiting for a clock edge.
- The tick counter is clog2(TICKS_PER_STEP) bits wide and never wraps beyond TICKS_PER_STEP−1.

## Structure
- Shared package `speaker_pkg` holds:
  - the note-code constants (REST, END, pitch codes);
  - the pitch-to-divider LUT function;
  - the state enum (IDLE, NOTE, GAP).
- One sub-module, `melody_rom`: combinational (melody, step) → 4-bit code, with per-melody tables.
- The FSM, tick counter and output registers live in `melody_sequencer`.

## Test plan
All scenarios use TICKS_PER_STEP=4 and GAP_TICKS=1.
1. Reset, then start with melody_sel=1 and loop_en=0.
   - Dividers follow 63775,63775,63775,0 / 71633×3,0 / 75758×3,0 / 95420×3,0 / 0×4 / repeat.
   - Then done pulses at cycle 41 after start, and busy drops.
2. Same stimulus with loop_en=1.
   - After step 9, step_idx returns to 0 with no done pulse. The sequence repeats identically for 3 loops.
3. Stop in the middle of step 2.
   - Next cycle: outputs 0, busy=0, no done.
   - A following start resumes from step 0.
4. start and stop in the same cycle while playing → stop wins (IDLE). A start alone while playing → restart at step 0 on the next cycle.
5. STEREO_MODE=1 with melody 1 → right divider is 127550 while left is 63775. Both channels are 0 during gaps and rests.
6. GAP_TICKS=0, plus rst_n pulsed low mid-step.
   - Notes play with no silent gaps.
   - Outputs go to 0 asynchronously during reset, and the block stays IDLE after reset is released.
